deserialize: RTL and testbench

Gathers RATIO consecutive narrow words from `din` and emits them as one wide word on `dout`, the first received word in the least-significant lane. It is the downstream counterpart to the word serializer: narrow streams produced by serialization are reassembled at the consuming end. Both sides use dti valid/ready handshakes.

---
 rtl/deserialize_pkg.sv | 16 +
 rtl/deserialize_oreg.sv | 74 +++++++
 rtl/deserialize.sv | 90 +++++++++
 tb/tb_deserialize.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deserialize_pkg.sv
// deserialize_pkg
// Shared definitions for the deserializer slice.
//   oreg_state_t      : output holding register states (COLLECT / FULL)
//   deserialize_cnt_w : width of the lane counter for a given RATIO
package deserialize_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } oreg_state_t;

    function automatic int deserialize_cnt_w(input int ratio);
        return $clog2(ratio);
    endfunction

endpackage

// File: rtl/deserialize_oreg.sv
// deserialize_oreg
// Output holding register for the deserializer. It captures a completed wide word
// and presents it until the consumer takes it.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   last        : the lane counter points at the final lane
//   din_valid   : narrow input valid
//   dout_ready  : wide output ready from the consumer
//   word        : wide word that would be completed by the current din beat
//   din_ready   : narrow input ready
//   dout_valid  : wide output valid (registered)
//   dout_data   : wide output data (registered)
module deserialize_oreg
    import deserialize_pkg::*;
#(
    parameter int WIDE_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              last,
    input  logic              din_valid,
    input  logic              dout_ready,
    input  logic [WIDE_W-1:0] word,
    output logic              din_ready,
    output logic              dout_valid,
    output logic [WIDE_W-1:0] dout_data
);

    oreg_state_t       state;
    oreg_state_t       state_next;
    logic [WIDE_W-1:0] dout_r;
    logic              complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= COLLECT;
            dout_r <= '0;
        end else begin
            state <= state_next;
            if (complete) begin
                dout_r <= word;
            end
        end
    end

    // The final lane is only accepted when the holding register is free or is
    // being emptied this cycle, so a completed word never overwrites a pending one.
    always_comb begin
        state_next = state;
        dout_valid = 1'b0;
        din_ready  = 1'b1;
        complete   = 1'b0;
        case (state)
            COLLECT: begin
                complete = din_valid & last;
                if (complete) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                dout_valid = 1'b1;
                din_ready  = dout_ready | ~last;
                complete   = din_valid & din_ready & last;
                if (dout_ready & ~complete) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    assign dout_data = dout_r;

endmodule

// File: rtl/deserialize.sv
// deserialize
// Gathers RATIO narrow words from din into one wide word on dout; the first word
// received lands in the least-significant lane.
// Configuration macro: DESERIALIZE_OUT_REG_EN
//   defined   : dout is registered (1-cycle latency, no din->dout combinational path)
//   undefined : zero-latency, the final lane passes straight through to dout
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   din_valid   : narrow input valid
//   din_ready   : narrow input ready
//   din_data    : narrow input word (DIN_W bits)
//   dout_valid  : wide output valid
//   dout_ready  : wide output ready
//   dout_data   : wide output word (DIN_W*RATIO bits)
module deserialize
    import deserialize_pkg::*;
#(
    parameter int DIN_W = 8,
    parameter int RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic [DIN_W-1:0]       din_data,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [DIN_W*RATIO-1:0] dout_data
);

    localparam int             CNT_W     = deserialize_cnt_w(RATIO);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]       count_s;
    logic [DIN_W-1:0]       lanes [RATIO-1];
    logic                   last;
    logic                   transfer;
    logic [DIN_W*RATIO-1:0] word;

    assign last     = (count_s == LAST_LANE);
    assign transfer = din_valid & din_ready;

    // Only lanes 0..RATIO-2 need storage: the final lane is always taken
    // directly from din in the cycle that completes the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_s <= '0;
            for (int i = 0; i < RATIO - 1; i++) begin
                lanes[i] <= '0;
            end
        end else if (transfer) begin
            count_s <= last ? '0 : count_s + 1'b1;
            for (int i = 0; i < RATIO - 1; i++) begin
                if (count_s == CNT_W'(i)) begin
                    lanes[i] <= din_data;
                end
            end
        end
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            word[i*DIN_W +: DIN_W] = lanes[i];
        end
        word[DIN_W*RATIO-1 -: DIN_W] = din_data;
    end

`ifdef DESERIALIZE_OUT_REG_EN
    deserialize_oreg #(
        .WIDE_W(DIN_W * RATIO)
    ) u_oreg (
        .clk       (clk),
        .rst       (rst),
        .last      (last),
        .din_valid (din_valid),
        .dout_ready(dout_ready),
        .word      (word),
        .din_ready (din_ready),
        .dout_valid(dout_valid),
        .dout_data (dout_data)
    );
`else
    // The final word completes only when the consumer takes it in the same cycle.
    assign dout_valid = din_valid & last;
    assign din_ready  = dout_ready | ~last;
    assign dout_data  = word;
`endif

endmodule

// File: tb/tb_deserialize.sv
// tb_deserialize
// Testbench for deserialize (DIN_W=8, RATIO=4). Works with and without
// DESERIALIZE_OUT_REG_EN; the reference model follows the same macro.
module tb_deserialize;

    localparam int DIN_W = 8;
    localparam int RATIO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  din_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;

    int checks = 0;
    int errors = 0;

    // Reference model state: words accepted toward the current wide word and,
    // for the registered build, the wide word waiting at the output.
    logic [7:0]  partial [$];
    logic        pend_valid = 1'b0;
    logic [31:0] pend_data  = '0;
    bit          known      = 1'b0;
    logic [31:0] beats [$];
    int          stalls     = 0;

    deserialize #(
        .DIN_W(DIN_W),
        .RATIO(RATIO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din_data  (din_data),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_data (dout_data)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Every falling edge: compare the DUT against the model, log delivered beats,
    // then advance the model to reflect the coming rising edge.
    always @(negedge clk) begin
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < partial.size(); i++) begin
            acc = acc | (32'(partial[i]) << (8 * i));
        end
`ifdef DESERIALIZE_OUT_REG_EN
        exp_valid = pend_valid;
        exp_data  = pend_data;
        exp_ready = !pend_valid || dout_ready || (partial.size() != RATIO - 1);
`else
        exp_valid = din_valid && (partial.size() == RATIO - 1);
        exp_data  = acc | (32'(din_data) << (8 * (RATIO - 1)));
        exp_ready = dout_ready || (partial.size() != RATIO - 1);
`endif
        if (known) begin
            check_output("din_ready", 32'(din_ready), 32'(exp_ready));
            check_output("dout_valid", 32'(dout_valid), 32'(exp_valid));
`ifdef DESERIALIZE_OUT_REG_EN
            check_output("dout_data", dout_data, exp_data);
`else
            if (exp_valid) begin
                check_output("dout_data", dout_data, exp_data);
            end
`endif
            if (din_valid && !din_ready) stalls++;
            if (dout_valid && dout_ready) beats.push_back(dout_data);
        end
        if (rst) begin
            partial.delete();
            pend_valid = 1'b0;
            pend_data  = '0;
            known      = 1'b1;
        end else if (known) begin
`ifdef DESERIALIZE_OUT_REG_EN
            if (pend_valid && dout_ready) pend_valid = 1'b0;
`endif
            if (din_valid && exp_ready) begin
                partial.push_back(din_data);
                if (partial.size() == RATIO) begin
                    acc = '0;
                    for (int i = 0; i < RATIO; i++) begin
                        acc = acc | (32'(partial[i]) << (8 * i));
                    end
`ifdef DESERIALIZE_OUT_REG_EN
                    pend_data  = acc;
                    pend_valid = 1'b1;
`endif
                    partial.delete();
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] w);
        bit done;
        done      = 1'b0;
        din_valid = 1'b1;
        din_data  = w;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (din_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout: word %h not accepted, required within 50 cycles", w);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        din_valid  = 1'b0;
        din_data   = '0;
        dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_output("reset_dout_valid", 32'(dout_valid), 32'h0);
        check_output("reset_din_ready", 32'(din_ready), 32'h1);
`ifdef DESERIALIZE_OUT_REG_EN
        check_output("reset_dout_data", dout_data, 32'h0);
`endif
        idle(1);

        // Scenario 1: single wide word
        $display("[TB] scenario 1: basic word");
        beats.delete();
        apply_stimulus(8'h11);
        apply_stimulus(8'h22);
        apply_stimulus(8'h33);
        apply_stimulus(8'h44);
        idle(3);
        check_output("s1_count", 32'(beats.size()), 32'd1);
        check_output("s1_beat0", beats[0], 32'h44332211);

        // Scenario 2: continuous stream, no stalls
        $display("[TB] scenario 2: continuous stream");
        beats.delete();
        stalls = 0;
        for (int i = 1; i <= 12; i++) apply_stimulus(8'(i));
        idle(3);
        check_output("s2_count", 32'(beats.size()), 32'd3);
        check_output("s2_beat0", beats[0], 32'h04030201);
        check_output("s2_beat1", beats[1], 32'h08070605);
        check_output("s2_beat2", beats[2], 32'h0C0B0A09);
        check_output("s2_stalls", 32'(stalls), 32'd0);

        // Scenario 3: back-pressure after the first wide word
        $display("[TB] scenario 3: back-pressure");
        beats.delete();
        for (int i = 1; i <= 4; i++) apply_stimulus(8'(i));
        dout_ready = 1'b0;
        for (int i = 5; i <= 7; i++) apply_stimulus(8'(i));
        din_valid = 1'b1;
        din_data  = 8'h08;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output("s3_din_ready_low", 32'(din_ready), 32'h0);
            check_output("s3_hold_valid", 32'(dout_valid), 32'h1);
`ifdef DESERIALIZE_OUT_REG_EN
            check_output("s3_hold_data", dout_data, 32'h04030201);
`else
            check_output("s3_hold_data", dout_data, 32'h08070605);
`endif
        end
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        apply_stimulus(8'h08);
        idle(3);
        check_output("s3_count", 32'(beats.size()), 32'd2);
        check_output("s3_beat0", beats[0], 32'h04030201);
        check_output("s3_beat1", beats[1], 32'h08070605);

        // Scenario 4: din_valid gaps between words
        $display("[TB] scenario 4: gapped input");
        beats.delete();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(8'hA0 + 8'(i));
            idle(1);
        end
        idle(2);
        check_output("s4_count", 32'(beats.size()), 32'd1);
        check_output("s4_beat0", beats[0], 32'hA3A2A1A0);

        // Scenario 5: reset discards a partial word
        $display("[TB] scenario 5: reset mid-word");
        beats.delete();
        apply_stimulus(8'hAA);
        apply_stimulus(8'hBB);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("s5_reset_dout_valid", 32'(dout_valid), 32'h0);
        check_output("s5_reset_din_ready", 32'(din_ready), 32'h1);
        idle(1);
        apply_stimulus(8'h55);
        apply_stimulus(8'h66);
        apply_stimulus(8'h77);
        apply_stimulus(8'h88);
        idle(3);
        check_output("s5_count", 32'(beats.size()), 32'd1);
        check_output("s5_beat0", beats[0], 32'h88776655);

        // Scenario 6: latency of the completing word and ready at the last lane
        $display("[TB] scenario 6: latency");
        beats.delete();
        apply_stimulus(8'h11);
        apply_stimulus(8'h22);
        apply_stimulus(8'h33);
        din_valid = 1'b1;
        din_data  = 8'h44;
        @(negedge clk);
`ifdef DESERIALIZE_OUT_REG_EN
        check_output("s6_valid_during_last", 32'(dout_valid), 32'h0);
`else
        check_output("s6_valid_during_last", 32'(dout_valid), 32'h1);
        check_output("s6_data_during_last", dout_data, 32'h44332211);
`endif
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        @(negedge clk);
`ifdef DESERIALIZE_OUT_REG_EN
        check_output("s6_valid_after_last", 32'(dout_valid), 32'h1);
        check_output("s6_data_after_last", dout_data, 32'h44332211);
`else
        check_output("s6_valid_after_last", 32'(dout_valid), 32'h0);
`endif
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        apply_stimulus(8'h01);
        apply_stimulus(8'h02);
        apply_stimulus(8'h03);
        din_valid = 1'b1;
        din_data  = 8'h04;
        @(negedge clk);
`ifdef DESERIALIZE_OUT_REG_EN
        check_output("s6_din_ready_last", 32'(din_ready), 32'h1);
`else
        check_output("s6_din_ready_last", 32'(din_ready), 32'h0);
`endif
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
`ifdef DESERIALIZE_OUT_REG_EN
        din_valid = 1'b0;
`else
        apply_stimulus(8'h04);
`endif
        idle(3);
        check_output("s6_count", 32'(beats.size()), 32'd2);
        check_output("s6_beat0", beats[0], 32'h44332211);
        check_output("s6_beat1", beats[1], 32'h04030201);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
